// File: rtl/three_body_update_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// three_body_pkg
// Shared definitions for the three-body physics update sequencer.
// Provides:
//   - field widths for positions, forces and accumulators
//   - pair codes (AB / AC / BC) and the sequencer state encoding
//   - reset positions for bodies A, B and C
//   - helpers that map a pair code to the indices of its two bodies
// ---------------------------------------------------------------------------
package three_body_pkg;

    localparam int POS_X_W = 9;
    localparam int POS_Y_W = 8;
    localparam int FORCE_W = 4;
    localparam int ACC_W   = 5;

    typedef enum logic [1:0] {
        PAIR_AB = 2'd0,
        PAIR_AC = 2'd1,
        PAIR_BC = 2'd2
    } pair_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } seq_state_t;

    // Packed as {C, B, A}, matching the pos_x / pos_y output layout.
    localparam logic [3*POS_X_W-1:0] INIT_POS_X = {9'd100, 9'd210, 9'd150};
    localparam logic [3*POS_Y_W-1:0] INIT_POS_Y = {8'd10,  8'd150, 8'd75};

    // Body index (0=A, 1=B, 2=C) of the first body of a pair: A, A, B.
    function automatic logic [1:0] first_body(input logic [1:0] pair);
        return (pair == PAIR_BC) ? 2'd1 : 2'd0;
    endfunction

    // Body index of the second body of a pair: B, C, C.
    function automatic logic [1:0] second_body(input logic [1:0] pair);
        return (pair == PAIR_AB) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/three_body_update_sequencer_if.sv
// ---------------------------------------------------------------------------
// three_body_update_sequencer_if
// Request/response link between the update sequencer and the shared
// pair-force unit.
//   req_valid/req_ready : request handshake (sequencer -> force unit)
//   req_pair            : 0=AB 1=AC 2=BC
//   req_p0x/req_p0y     : position of the first body of the pair
//   req_p1x/req_p1y     : position of the second body of the pair
//   rsp_valid           : one-cycle force result strobe
//   rsp_fx/rsp_fy       : signed force on the first body toward the second
// Modports: master = sequencer side, slave = force unit side.
// ---------------------------------------------------------------------------
interface three_body_update_sequencer_if;
    import three_body_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_pair;
    logic [POS_X_W-1:0] req_p0x;
    logic [POS_Y_W-1:0] req_p0y;
    logic [POS_X_W-1:0] req_p1x;
    logic [POS_Y_W-1:0] req_p1y;
    logic               rsp_valid;
    logic [FORCE_W-1:0] rsp_fx;
    logic [FORCE_W-1:0] rsp_fy;

    modport master (
        output req_valid, req_pair, req_p0x, req_p0y, req_p1x, req_p1y,
        input  req_ready, rsp_valid, rsp_fx, rsp_fy
    );

    modport slave (
        input  req_valid, req_pair, req_p0x, req_p0y, req_p1x, req_p1y,
        output req_ready, rsp_valid, rsp_fx, rsp_fy
    );

endinterface

// File: rtl/three_body_update_sequencer_accum.sv
// ---------------------------------------------------------------------------
// three_body_accum
// Per-body, per-axis signed acceleration accumulators (3 bodies x 2 axes).
// A pair force is added to the pair's first body and subtracted from its
// second body.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear          : zero all accumulators (start of a frame update)
//   en             : apply fx/fy to the bodies of 'pair'
//   pair           : pair code selecting the two bodies
//   fx, fy         : signed force on the first body
//   acc_x, acc_y   : accumulator values, index 0=A 1=B 2=C
// ---------------------------------------------------------------------------
module three_body_accum
    import three_body_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      en,
    input  logic [1:0]                pair,
    input  logic signed [FORCE_W-1:0] fx,
    input  logic signed [FORCE_W-1:0] fy,
    output logic signed [ACC_W-1:0]   acc_x [3],
    output logic signed [ACC_W-1:0]   acc_y [3]
);

    logic signed [ACC_W-1:0] dx;
    logic signed [ACC_W-1:0] dy;

    assign dx = ACC_W'(fx);
    assign dy = ACC_W'(fy);

    // Forces are bounded to +/-2 and each body sees two pairs, so the sums
    // stay within +/-4 and cannot overflow the accumulator width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                acc_x[i] <= '0;
                acc_y[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (clear) begin
                    acc_x[i] <= '0;
                    acc_y[i] <= '0;
                end else if (en) begin
                    if (2'(i) == first_body(pair)) begin
                        acc_x[i] <= acc_x[i] + dx;
                        acc_y[i] <= acc_y[i] + dy;
                    end else if (2'(i) == second_body(pair)) begin
                        acc_x[i] <= acc_x[i] - dx;
                        acc_y[i] <= acc_y[i] - dy;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/three_body_update_sequencer.sv
// ---------------------------------------------------------------------------
// three_body_update_sequencer
// Once per frame, time-multiplexes one shared pair-force unit over pairs
// AB, AC, BC, accumulates per-body acceleration, then commits velocity and
// position for all three bodies in a single cycle.
// Ports:
//   clk, rst_n       : pixel clock, asynchronous active-low reset
//   frame_tick       : frame start pulse (ignored while paused)
//   pause            : level, suspends frame-driven updates
//   step             : single update pulse, honoured only while paused
//   clr_flags        : clears overrun and timeout_err
//   bus              : request/response link to the pair-force unit
//   pos_x / pos_y    : {C,B,A} committed positions
//   commit           : pulse, positions change at the end of this cycle
//   busy             : sequencer is not idle
//   overrun          : sticky, start arrived while busy
//   timeout_err      : sticky, a pair response timed out
// ---------------------------------------------------------------------------
module three_body_update_sequencer
    import three_body_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int VEL_W       = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_tick,
    input  logic                     pause,
    input  logic                     step,
    input  logic                     clr_flags,
    three_body_update_sequencer_if.master bus,
    output logic [3*POS_X_W-1:0]     pos_x,
    output logic [3*POS_Y_W-1:0]     pos_y,
    output logic                     commit,
    output logic                     busy,
    output logic                     overrun,
    output logic                     timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    seq_state_t state_q, state_d;
    logic [1:0]    pair_q;
    logic [TW-1:0] timer_q;

    logic start, rsp_take, time_out, advance, last_pair;
    logic signed [FORCE_W-1:0] f_x, f_y;

    logic [POS_X_W-1:0]      px [3];
    logic [POS_Y_W-1:0]      py [3];
    logic signed [VEL_W-1:0] vx [3];
    logic signed [VEL_W-1:0] vy [3];
    logic signed [ACC_W-1:0] acc_x [3];
    logic signed [ACC_W-1:0] acc_y [3];

    assign start     = (frame_tick & ~pause) | (step & pause);
    assign rsp_take  = (state_q == ST_WAIT) && bus.rsp_valid;
    assign time_out  = (state_q == ST_WAIT) && !bus.rsp_valid
                       && (timer_q == TW'(TIMEOUT_CYC - 1));
    assign advance   = rsp_take || time_out;
    assign last_pair = (pair_q == PAIR_BC);

    // A timed-out pair contributes zero force but still advances.
    assign f_x = rsp_take ? signed'(bus.rsp_fx) : '0;
    assign f_y = rsp_take ? signed'(bus.rsp_fy) : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)         state_d = ST_REQ;
            ST_REQ:    if (bus.req_ready) state_d = ST_WAIT;
            ST_WAIT:   if (advance)       state_d = last_pair ? ST_COMMIT : ST_REQ;
            ST_COMMIT:                    state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Outputs. Operands come from committed positions, which cannot change
    // until COMMIT, so they are stable for the whole request.
    always_comb begin
        bus.req_valid = (state_q == ST_REQ);
        commit        = (state_q == ST_COMMIT);
        busy          = (state_q != ST_IDLE);
        bus.req_pair  = pair_q;
        bus.req_p0x   = px[first_body(pair_q)];
        bus.req_p0y   = py[first_body(pair_q)];
        bus.req_p1x   = px[second_body(pair_q)];
        bus.req_p1y   = py[second_body(pair_q)];
    end

    // Pair index and response timer. The pair returns to AB after the last
    // pair so req_pair rests at 0 between updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q  <= 2'd0;
            timer_q <= '0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                pair_q <= PAIR_AB;
            end else if (state_q == ST_REQ && bus.req_ready) begin
                timer_q <= '0;
            end else if (state_q == ST_WAIT) begin
                if (advance) pair_q  <= last_pair ? 2'd0 : pair_q + 2'd1;
                else         timer_q <= timer_q + 1'b1;
            end
        end
    end

    // Sticky flags; a new set event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (start && state_q != ST_IDLE) overrun <= 1'b1;
            else if (clr_flags)              overrun <= 1'b0;
            if (time_out)                    timeout_err <= 1'b1;
            else if (clr_flags)              timeout_err <= 1'b0;
        end
    end

    three_body_accum u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == ST_IDLE && start),
        .en    (advance),
        .pair  (pair_q),
        .fx    (f_x),
        .fy    (f_y),
        .acc_x (acc_x),
        .acc_y (acc_y)
    );

    // Commit: positions move by the pre-update velocity (semi-implicit order
    // reversed on purpose), velocity and position both wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                px[i] <= INIT_POS_X[i*POS_X_W +: POS_X_W];
                py[i] <= INIT_POS_Y[i*POS_Y_W +: POS_Y_W];
                vx[i] <= '0;
                vy[i] <= '0;
            end
        end else if (state_q == ST_COMMIT) begin
            for (int i = 0; i < 3; i++) begin
                vx[i] <= vx[i] + VEL_W'(acc_x[i]);
                vy[i] <= vy[i] + VEL_W'(acc_y[i]);
                px[i] <= px[i] + POS_X_W'(vx[i]);
                py[i] <= py[i] + POS_Y_W'(vy[i]);
            end
        end
    end

    assign pos_x = {px[2], px[1], px[0]};
    assign pos_y = {py[2], py[1], py[0]};

endmodule
